ring_nic_if: RTL
================

RING_NIC_IF -- requirements
Module: ring_nic_if

Interface
REQ-001 SHALL have parameter DEPTH, default 2, giving entries per channel FIFO (legal values 2 only).
REQ-002 SHALL have parameter W, default 64, giving the packet/data width.
REQ-003 CLK  input  1  system clock; all state updates on posedge.
REQ-004 RESET  input  1  reset, synchronous, active-high.
REQ-005 addr  input  2  processor register select: 00 in-data, 01 in-status, 10 out-data, 11 out-status.
REQ-006 d_in  input  64  processor write data.
REQ-007 d_out  output  64  processor read data.
REQ-008 nicEn  input  1  access enable.
REQ-009 nicWrEn  input  1  1 = write, 0 = read; qualified by nicEn.
REQ-010 net_si  input  1  router presents a packet on net_di.
REQ-011 net_ri  input  1  router can accept a packet this cycle.
REQ-012 net_di  input  64  packet from router.
REQ-013 net_so  output  1  NIC injects net_do this cycle.
REQ-014 net_ro  output  1  NIC can accept a packet this cycle.
REQ-015 net_do  output  64  packet to router; head of output FIFO.
REQ-016 net_polarity  input  1  current router phase (0 even, 1 odd).

Function
REQ-017 Each channel SHALL be a 2-entry FIFO with 2-bit occupancy count (0..2) and wrapping 1-bit read/write pointers; order strictly preserved.
REQ-018 net_ro SHALL equal (in_count != 2), from registered state only.
REQ-019 Input push SHALL occur at posedge when net_si && net_ro; net_si with net_ro low is ignored.
REQ-020 Input pop SHALL occur at posedge when nicEn && !nicWrEn && addr==00 && in_count != 0; a read of an empty input FIFO returns the last head-slot contents and changes no state.
REQ-021 Output push SHALL occur at posedge when nicEn && nicWrEn && addr==10 && out_count != 2; a write when full is dropped even if an injection frees a slot that cycle.
REQ-022 net_so SHALL be combinational: (out_count != 0) && net_ri && (net_polarity == net_do[0]); output pop occurs at posedge when net_so is high.
REQ-023 net_do SHALL always show the output FIFO head entry (bit 0 = virtual channel).
REQ-024 d_out SHALL be combinational: addr 00 -> input head; 01 -> {62'b0, in_count}; 11 -> {62'b0, out_count}; addr 10, writes, or nicEn low -> 0.
REQ-025 Simultaneous push and pop on one channel at count 1 SHALL leave count 1 and advance both pointers; at count 0 only the push takes effect; at count 2 only the pop takes effect.
REQ-026 Writes to addr 00, 01, 11 SHALL be ignored.
REQ-027 Latency: packet pushed from net_di at edge N SHALL be readable at addr 00 in the cycle after edge N; processor write at edge N SHALL make net_so eligible in the cycle after edge N.

Reset
REQ-028 While RESET is high at posedge, both counts and all pointers SHALL clear to 0; FIFO storage is not cleared.
REQ-029 During and after reset: net_ro=1, net_so=0, d_out=0 unless a read of addr 01/11 (returns 0) or 00 is in progress.
REQ-030 RESET SHALL override any simultaneous push/pop; mid-operation reset discards all buffered packets.

Verification
REQ-031 Reset, then read addr 01 and 11 -> d_out=0 both; net_ro=1, net_so=0.
REQ-032 Router pushes 0x0000_0000_0000_00A1 then 0x...00A2 on consecutive cycles; third net_si -> net_ro=0 after two, third dropped; reads of addr 00 return A1 then A2; status goes 2,1,0.
REQ-033 Processor writes 0x8000_0000_0000_0005 (VC=1) with net_ri=1, net_polarity=0 -> net_so stays 0; polarity toggles to 1 -> net_so=1 for one cycle, net_do=0x8000_0000_0000_0005, out status 0 after.
REQ-034 Fill output FIFO (2 writes, net_ri=0); third write 0x...0033 while injection fires -> 0x...0033 dropped, out status 1.
REQ-035 in_count=1, same-cycle net_si push of 0x...00B2 and processor pop -> pop returns prior head, in status remains 1, next read returns 0x...00B2.
REQ-036 Both FIFOs holding 2 packets, RESET pulsed 1 cycle -> both statuses 0, net_ro=1, net_so=0 next cycle.

Source files
------------

// File: rtl/ring_nic_if_if.sv
// Processor register bus and router link bundle for the ring NIC.
// The slave modport is the NIC side; master is the processor/router side.
interface ring_nic_if_if #(
  parameter int unsigned W = 64
);
  logic [1:0]   addr;
  logic [W-1:0] d_in;
  logic [W-1:0] d_out;
  logic         nicEn;
  logic         nicWrEn;
  logic         net_si;
  logic         net_ri;
  logic [W-1:0] net_di;
  logic         net_so;
  logic         net_ro;
  logic [W-1:0] net_do;
  logic         net_polarity;

  modport slave (
    input  addr, d_in, nicEn, nicWrEn, net_si, net_ri, net_di, net_polarity,
    output d_out, net_so, net_ro, net_do
  );

  modport master (
    output addr, d_in, nicEn, nicWrEn, net_si, net_ri, net_di, net_polarity,
    input  d_out, net_so, net_ro, net_do
  );
endinterface

// File: rtl/ring_nic_if.sv
// Ring network interface: a 2-entry input FIFO (router -> processor) and a 2-entry
// output FIFO (processor -> router) with polarity-gated injection.
module ring_nic_if #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 64
) (
  input logic          CLK,
  input logic          RESET,
  ring_nic_if_if.slave bus
);
  localparam logic [1:0] Full = 2'(DEPTH);

  logic [W-1:0] in_mem_q  [2];
  logic [W-1:0] out_mem_q [2];
  logic         in_rd_q, in_wr_q, out_rd_q, out_wr_q;
  logic [1:0]   in_cnt_q, out_cnt_q;
  logic         in_push, in_pop, out_push, out_pop, rd_en;

  always_comb begin
    rd_en        = bus.nicEn && !bus.nicWrEn;
    bus.net_ro   = (in_cnt_q != Full);
    in_push      = bus.net_si && bus.net_ro;
    in_pop       = rd_en && (bus.addr == 2'b00) && (in_cnt_q != 2'd0);
    // Full check uses registered count, so a same-cycle injection cannot make room.
    out_push     = bus.nicEn && bus.nicWrEn && (bus.addr == 2'b10) && (out_cnt_q != Full);
    bus.net_do   = out_mem_q[out_rd_q];
    bus.net_so   = (out_cnt_q != 2'd0) && bus.net_ri && (bus.net_polarity == bus.net_do[0]);
    out_pop      = bus.net_so;
    bus.d_out    = '0;
    if (rd_en) begin
      unique case (bus.addr)
        2'b00:   bus.d_out = in_mem_q[in_rd_q];
        2'b01:   bus.d_out = {{(W-2){1'b0}}, in_cnt_q};
        2'b11:   bus.d_out = {{(W-2){1'b0}}, out_cnt_q};
        default: bus.d_out = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      in_cnt_q  <= 2'd0;
      in_rd_q   <= 1'b0;
      in_wr_q   <= 1'b0;
      out_cnt_q <= 2'd0;
      out_rd_q  <= 1'b0;
      out_wr_q  <= 1'b0;
    end else begin
      in_cnt_q  <= in_cnt_q + {1'b0, in_push} - {1'b0, in_pop};
      out_cnt_q <= out_cnt_q + {1'b0, out_push} - {1'b0, out_pop};
      if (in_push)  in_wr_q  <= ~in_wr_q;
      if (in_pop)   in_rd_q  <= ~in_rd_q;
      if (out_push) out_wr_q <= ~out_wr_q;
      if (out_pop)  out_rd_q <= ~out_rd_q;
    end
  end

  // Storage is never cleared; stale contents remain visible on empty reads.
  always_ff @(posedge CLK) begin
    if (!RESET && in_push)  in_mem_q[in_wr_q]   <= bus.net_di;
    if (!RESET && out_push) out_mem_q[out_wr_q] <= bus.d_in;
  end
endmodule
